montgomery_reduce_scheduler: RTL and testbench
==============================================

// Module: montgomery_reduce_scheduler
// PURPOSE
// Shares one serialized Montgomery reduction core among NUM_REQ requesters, e.g. NTT butterfly lanes.
// - Arbitrates round-robin and captures the winner's operand and the modulus.
// - Sequences the core: operand load via core clear, start pulse, wait for done.
// - Returns the result tagged with the requester ID over a valid/ready response channel.
// - Sits between the NTT datapath and the reduction core; exactly one reduction is in flight.
// PARAMETERS
// NUM_REQ        4     number of requesters (>=2)
// WIDTH          64    operand/modulus/result width
// TIMEOUT_CYCLES 256   watchdog limit in WAIT (used only with MONT_SCHED_TIMEOUT_EN)
// PORTS
// clk_i          in   1                 clock
// rst_ni         in   1                 reset, asynchronous, active-low
// req_valid_i    in   NUM_REQ           per-requester operand valid
// req_ready_o    out  NUM_REQ           per-requester accept; one-hot or zero
// req_x_i        in   NUM_REQ*WIDTH     packed operands; lane i = [i*WIDTH +: WIDTH]
// m_i            in   WIDTH             modulus, sampled at accept
// resp_valid_o   out  1                 result available
// resp_ready_i   in   1                 consumer accepts result
// resp_data_o    out  WIDTH             reduced result
// resp_id_o      out  $clog2(NUM_REQ)   index of the originating requester
// resp_err_o     out  1                 timeout abort flag; tied 0 without the macro
// busy_o         out  1                 high whenever state != IDLE
// core_clear_no  out  1                 active-low core clear; core loads core_x_o while low
// core_start_o   out  1                 one-cycle core start pulse
// core_x_o       out  WIDTH             captured operand
// core_m_o       out  WIDTH             captured modulus
// core_result_i  in   WIDTH             core result
// core_valid_i   in   1                 core done; level, held until the next clear
// BEHAVIOUR
// - Reset (async assert, sync release) drives:
//   - state = IDLE, rr_ptr = NUM_REQ-1.
//   - All outputs 0, except core_clear_no = 1.
//   - Operand/result/ID registers = 0.
// - States and transitions:
//   - IDLE -> LOAD. Grant = first i with req_valid_i[i] set, scanning from rr_ptr+1 modulo NUM_REQ.
//     - req_ready_o[grant] = 1 combinationally, only in IDLE. The accept completes in that cycle.
//     - On accept: x_q <= lane, m_q <= m_i, id_q <= grant, rr_ptr <= grant.
//     - No valid input: stay in IDLE, req_ready_o = 0.
//   - LOAD (1 cycle): core_clear_no = 0 with core_x_o = x_q. -> START.
//   - START (1 cycle): core_start_o = 1. -> WAIT.
//   - WAIT: hold until core_valid_i = 1, then res_q <= core_result_i. -> RESP.
//   - RESP: resp_valid_o = 1. data, id and err stay stable until resp_ready_i = 1, then -> IDLE.
//     - A new grant is possible in the cycle after the handshake, not in the same cycle.
// - Latency, accept to resp_valid_o: 3 + Tcore cycles, where Tcore = cycles from start to core_valid_i.
// - core_x_o and core_m_o hold x_q and m_q from LOAD through RESP.
// - Changes on m_i or req_x_i while busy_o = 1 have no effect.
// - core_valid_i in IDLE, LOAD or START is ignored; it is stale from the previous operation.
// - Round-robin fairness:
//   - A requester holding valid is granted within NUM_REQ grants.
//   - The grant pointer wraps from NUM_REQ-1 to 0.
//   - A single active requester is granted back-to-back.
// - Requesters may drop req_valid_i before being granted; no state is kept for them.
// - Reset mid-operation aborts immediately: no response, pointer restored to NUM_REQ-1.
// CONFIGURATION
// - MONT_SCHED_TIMEOUT_EN defined:
//   - 16-bit watchdog cleared on entry to WAIT and incremented each WAIT cycle.
//   - When it reaches TIMEOUT_CYCLES with no core_valid_i:
//     - go to RESP with resp_err_o = 1 and resp_data_o = 0;
//     - pulse core_clear_no low for one cycle on leaving WAIT.
//   - resp_err_o = 0 on normal completion.
// - MONT_SCHED_TIMEOUT_EN undefined: no counter; WAIT is unbounded; resp_err_o is constant 0.
// TESTING
// - Single request, real core: lane 0, x=1, m=17, resp_ready_i=1.
//   -> resp_data_o=8, resp_id_o=0, 1-cycle resp_valid_o.
// - All four lanes valid continuously -> grant order 0,1,2,3,0; each lane gets one response per round.
// - Lane 2 only, x=34, m=17 -> resp_data_o=0, id=2; a second lane-2 request is granted the cycle after RESP.
// - Backpressure: resp_ready_i=0 for 10 cycles in RESP.
//   -> outputs stable, req_ready_o=0, no new grant until the handshake.
// - Reset asserted during WAIT.
//   -> all outputs 0 and core_clear_no=1 asynchronously; the next grant starts at lane 0.
// - With MONT_SCHED_TIMEOUT_EN: stub core never asserts valid, TIMEOUT_CYCLES=8.
//   -> RESP after 8 WAIT cycles, resp_err_o=1, resp_data_o=0.

Source files
------------

// File: rtl/montgomery_reduce_scheduler_if.sv
// Bundle of request, response and core-side signals for montgomery_reduce_scheduler.
// The slave modport is the scheduler's view; master is the surrounding datapath/core view.
interface montgomery_reduce_scheduler_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 64
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*WIDTH-1:0] req_x_i;
    logic [WIDTH-1:0]         m_i;
    logic                     resp_valid_o;
    logic                     resp_ready_i;
    logic [WIDTH-1:0]         resp_data_o;
    logic [IdW-1:0]           resp_id_o;
    logic                     resp_err_o;
    logic                     busy_o;
    logic                     core_clear_no;
    logic                     core_start_o;
    logic [WIDTH-1:0]         core_x_o;
    logic [WIDTH-1:0]         core_m_o;
    logic [WIDTH-1:0]         core_result_i;
    logic                     core_valid_i;

    modport slave (
        input  req_valid_i, req_x_i, m_i, resp_ready_i, core_result_i, core_valid_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_id_o, resp_err_o, busy_o,
               core_clear_no, core_start_o, core_x_o, core_m_o
    );

    modport master (
        output req_valid_i, req_x_i, m_i, resp_ready_i, core_result_i, core_valid_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_id_o, resp_err_o, busy_o,
               core_clear_no, core_start_o, core_x_o, core_m_o
    );
endinterface

// File: rtl/montgomery_reduce_scheduler.sv
// Round-robin scheduler sharing one serialized Montgomery reduction core among NUM_REQ
// requesters. One reduction in flight: IDLE -> LOAD -> START -> WAIT -> RESP -> IDLE.
// Optional feature macro: MONT_SCHED_TIMEOUT_EN adds a WAIT watchdog that aborts with
// resp_err_o = 1 after TIMEOUT_CYCLES cycles without core_valid_i.
module montgomery_reduce_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic                          clk_i,
    input logic                          rst_ni,
    montgomery_reduce_scheduler_if.slave bus
);
    localparam int unsigned IdW = $clog2(NUM_REQ);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StStart = 3'd2;
    localparam logic [2:0] StWait  = 3'd3;
    localparam logic [2:0] StResp  = 3'd4;

    logic [2:0]         r_state;
    logic [IdW-1:0]     r_rr_ptr;
    logic [IdW-1:0]     r_id;
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_res;

    logic               w_found;
    logic [IdW-1:0]     w_grant;
    logic [IdW-1:0]     w_idx;
    logic [NUM_REQ-1:0] w_ready;
    logic [WIDTH-1:0]   w_lane;

`ifdef MONT_SCHED_TIMEOUT_EN
    logic [15:0]        r_wdog;
    logic               r_err;
    logic               r_abort_clr;
`endif

    // Pick the first valid lane after the previous grant, wrapping modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            w_idx = IdW'((32'(r_rr_ptr) + off) % NUM_REQ);
            if (!w_found && bus.req_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    // Accept strobe to the winner, only while idle.
    always_comb begin
        w_ready = '0;
        if (r_state == StIdle && w_found) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_lane = bus.req_x_i[32'(w_grant) * WIDTH +: WIDTH];

    // Sequencer state, captured operands and result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= StIdle;
            r_rr_ptr    <= IdW'(NUM_REQ - 1);
            r_id        <= '0;
            r_x         <= '0;
            r_m         <= '0;
            r_res       <= '0;
`ifdef MONT_SCHED_TIMEOUT_EN
            r_wdog      <= '0;
            r_err       <= 1'b0;
            r_abort_clr <= 1'b0;
`endif
        end else begin
`ifdef MONT_SCHED_TIMEOUT_EN
            r_abort_clr <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_x      <= w_lane;
                        r_m      <= bus.m_i;
                        r_id     <= w_grant;
                        r_rr_ptr <= w_grant;
                        r_state  <= StLoad;
                    end
                end
                StLoad: r_state <= StStart;
                StStart: begin
`ifdef MONT_SCHED_TIMEOUT_EN
                    r_wdog  <= '0;
`endif
                    r_state <= StWait;
                end
                StWait: begin
                    if (bus.core_valid_i) begin
                        r_res   <= bus.core_result_i;
`ifdef MONT_SCHED_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                        r_state <= StResp;
                    end
`ifdef MONT_SCHED_TIMEOUT_EN
                    else if (r_wdog == 16'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: report an error and flush the stuck core.
                        r_res       <= '0;
                        r_err       <= 1'b1;
                        r_abort_clr <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
`endif
                end
                StResp: begin
                    if (bus.resp_ready_i) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.req_ready_o  = w_ready;
    assign bus.resp_valid_o = (r_state == StResp);
    assign bus.resp_data_o  = r_res;
    assign bus.resp_id_o    = r_id;
    assign bus.busy_o       = (r_state != StIdle);
    assign bus.core_start_o = (r_state == StStart);
    assign bus.core_x_o     = r_x;
    assign bus.core_m_o     = r_m;

`ifdef MONT_SCHED_TIMEOUT_EN
    assign bus.core_clear_no = !((r_state == StLoad) || r_abort_clr);
    assign bus.resp_err_o    = r_err;
`else
    assign bus.core_clear_no = (r_state != StLoad);
    assign bus.resp_err_o    = 1'b0;
`endif
endmodule

// File: tb/tb_montgomery_reduce_scheduler.sv
// Self-checking bench: behavioural core stub (bit-serial REDC, R = 2^bitlen(m)) plus a
// transaction-level model of the scheduler checked against the DUT every cycle.
module tb_montgomery_reduce_scheduler;
    localparam int unsigned NR = 4;
    localparam int unsigned W  = 16;
    localparam int unsigned TO = 8;
    localparam int unsigned IW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    montgomery_reduce_scheduler_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();

    montgomery_reduce_scheduler #(
        .NUM_REQ(NR), .WIDTH(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    // Scheduler model
    bit          m_busy, m_resp, m_abort, m_err;
    int          m_age;
    int          m_rr = NR - 1;
    int          m_id;
    logic [W-1:0] m_x, m_m, m_data;
    int          grants[$];
    int          n_resp = 0, resp_len = 0, last_len = 0;
    int          acc_cyc = 0, hs_cyc = 0, resp_start_cyc = 0;
    logic [W-1:0] last_data;
    logic [IW-1:0] last_id;
    logic        last_err;

    // Core stub
    int          cd = 0;
    bit          st_clr = 0, st_never = 0;
    logic [W-1:0] st_x, st_m, st_res;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic int bitlen(longint v);
        int n = 0;
        while (v > 0) begin n++; v = v >> 1; end
        return n;
    endfunction

    // Expected result: x * (2^-n) mod m by modular arithmetic.
    function automatic longint mont(longint x, longint m);
        longint p = 1;
        longint h = (m + 1) / 2;
        int n = bitlen(m);
        for (int i = 0; i < n; i++) p = (p * h) % m;
        return ((x % m) * p) % m;
    endfunction

    // What the stub core computes: bit-serial REDC with one final subtraction.
    function automatic longint redc(longint x, longint m);
        longint t = x;
        int n = bitlen(m);
        for (int i = 0; i < n; i++) begin
            if (t[0]) t = t + m;
            t = t >> 1;
        end
        if (t >= m) t = t - m;
        return t;
    endfunction

    function automatic int pick(logic [NR-1:0] v, int rr);
        for (int k = 1; k <= NR; k++) begin
            if (v[(rr + k) % NR]) return (rr + k) % NR;
        end
        return -1;
    endfunction

    task automatic step();
        logic [NR-1:0] exp_ready;
        int g;
        @(negedge clk);
        cyc++;
        exp_ready = '0;
        g = -1;
        if (!m_busy) begin
            g = pick(bus.req_valid_i, m_rr);
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        chk("req_ready", 64'(bus.req_ready_o), 64'(exp_ready));
        chk("busy", 64'(bus.busy_o), 64'(m_busy));
        chk("core_clear_n", 64'(bus.core_clear_no), 64'(!(m_busy && m_age == 1) && !m_abort));
        chk("core_start", 64'(bus.core_start_o), 64'(m_busy && m_age == 2 && !m_resp));
        chk("resp_valid", 64'(bus.resp_valid_o), 64'(m_resp));
        if (m_busy) begin
            chk("core_x", 64'(bus.core_x_o), 64'(m_x));
            chk("core_m", 64'(bus.core_m_o), 64'(m_m));
        end
        if (m_resp) begin
            chk("resp_data", 64'(bus.resp_data_o), 64'(m_data));
            chk("resp_id", 64'(bus.resp_id_o), 64'(m_id));
            chk("resp_err", 64'(bus.resp_err_o), 64'(m_err));
        end
        // Stub core observes clear and start.
        if (!bus.core_clear_no) begin
            st_clr = 1; st_x = bus.core_x_o; st_m = bus.core_m_o; cd = 0;
        end
        if (bus.core_start_o) begin
            st_res = W'(redc(longint'(st_x), longint'(st_m)));
            cd = st_never ? 0 : bitlen(longint'(st_m)) + int'($urandom_range(0, 3));
        end
        // Model advance for the coming edge.
        m_abort = 0;
        if (!m_busy) begin
            if (g >= 0) begin
                m_busy = 1; m_age = 1; m_err = 0;
                m_x = bus.req_x_i[g*W +: W];
                m_m = bus.m_i;
                m_id = g; m_rr = g;
                m_data = W'(mont(longint'(m_x), longint'(m_m)));
                grants.push_back(g);
                acc_cyc = cyc;
            end
        end else if (!m_resp) begin
            if (m_age >= 3 && bus.core_valid_i) begin
                m_resp = 1; resp_len = 0; resp_start_cyc = cyc + 1;
            end
`ifdef MONT_SCHED_TIMEOUT_EN
            else if (m_age - 2 == TO) begin
                m_resp = 1; m_err = 1; m_data = '0; m_abort = 1;
                resp_len = 0; resp_start_cyc = cyc + 1;
            end
`endif
            else m_age++;
        end else begin
            resp_len++;
            if (bus.resp_ready_i) begin
                m_busy = 0; m_resp = 0;
                last_len = resp_len; hs_cyc = cyc; n_resp++;
                last_data = bus.resp_data_o; last_id = bus.resp_id_o; last_err = bus.resp_err_o;
            end
        end
        @(posedge clk);
        #1;
        if (st_clr) begin bus.core_valid_i = 1'b0; st_clr = 0; end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin bus.core_valid_i = 1'b1; bus.core_result_i = st_res; end
        end
        if (!bus.core_valid_i) bus.core_result_i = W'($urandom);
    endtask

    task automatic drive_rand();
        logic [W-1:0] m;
        m = W'($urandom_range(1, 16383) * 2 + 1);
        bus.m_i = m;
        for (int k = 0; k < NR; k++) bus.req_x_i[k*W +: W] = W'($urandom_range(0, 2 * m - 1));
        bus.req_valid_i = NR'($urandom);
        bus.resp_ready_i = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_resp(int target, string name);
        for (int i = 0; i < 500 && n_resp < target; i++) step();
        chk(name, 64'(n_resp >= target), 64'd1);
    endtask

    task automatic drain();
        bus.req_valid_i = '0;
        bus.resp_ready_i = 1'b1;
        for (int i = 0; i < 500 && m_busy; i++) step();
        chk("drain_timeout", 64'(bus.busy_o), 64'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_clear_n", 64'(bus.core_clear_no), 64'd1);
        chk("rst_start", 64'(bus.core_start_o), 64'd0);
        chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'd0);
        chk("rst_data", 64'(bus.resp_data_o), 64'd0);
        chk("rst_id", 64'(bus.resp_id_o), 64'd0);
        chk("rst_err", 64'(bus.resp_err_o), 64'd0);
        chk("rst_core_x", 64'(bus.core_x_o), 64'd0);
        chk("rst_core_m", 64'(bus.core_m_o), 64'd0);
    endtask

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_abort = 0; m_age = 0; m_rr = NR - 1;
        cd = 0; st_clr = 0;
        bus.core_valid_i = 1'b0;
    endtask

    int h1;

    initial begin
        bus.req_valid_i = '0; bus.req_x_i = '0; bus.m_i = '0;
        bus.resp_ready_i = 1'b0; bus.core_result_i = '0; bus.core_valid_i = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #2 chk_reset_outputs();
        @(posedge clk); #2 rst_n = 1'b1;

        // All lanes valid: grant order 0,1,2,3,0.
        bus.m_i = W'(17);
        for (int k = 0; k < NR; k++) bus.req_x_i[k*W +: W] = W'(k + 1);
        bus.req_valid_i = '1;
        bus.resp_ready_i = 1'b1;
        for (int i = 0; i < 500 && grants.size() < 5; i++) step();
        chk("rr_grant_count", 64'(grants.size() >= 5), 64'd1);
        if (grants.size() >= 5) begin
            chk("rr_g0", 64'(grants[0]), 64'd0);
            chk("rr_g1", 64'(grants[1]), 64'd1);
            chk("rr_g2", 64'(grants[2]), 64'd2);
            chk("rr_g3", 64'(grants[3]), 64'd3);
            chk("rr_g4", 64'(grants[4]), 64'd0);
        end
        drain();

        // Single request lane 0, x=1, m=17 -> 8, one-cycle response.
        bus.req_x_i[0 +: W] = W'(1);
        bus.m_i = W'(17);
        bus.req_valid_i = 4'b0001;
        for (int i = 0; i < 20 && !m_busy; i++) step();
        bus.req_valid_i = '0;
        wait_resp(n_resp + 1, "single_timeout");
        chk("single_data", 64'(last_data), 64'd8);
        chk("single_id", 64'(last_id), 64'd0);
        chk("single_len", 64'(last_len), 64'd1);
        drain();

        // Lane 2 only, x=34, m=17 -> 0; back-to-back re-grant the cycle after the handshake.
        bus.req_x_i[2*W +: W] = W'(34);
        bus.req_valid_i = 4'b0100;
        wait_resp(n_resp + 1, "lane2_timeout");
        chk("lane2_data", 64'(last_data), 64'd0);
        chk("lane2_id", 64'(last_id), 64'd2);
        h1 = hs_cyc;
        step();
        chk("lane2_regrant", 64'(acc_cyc), 64'(h1 + 1));
        drain();

        // Backpressure for 10 cycles in RESP.
        bus.req_valid_i = 4'b1011;
        bus.resp_ready_i = 1'b0;
        for (int i = 0; i < 100 && !m_resp; i++) step();
        repeat (10) step();
        bus.resp_ready_i = 1'b1;
        wait_resp(n_resp + 1, "bp_timeout");
        chk("bp_len", 64'(last_len), 64'd11);
        drain();

        // Asynchronous reset during WAIT; next grant restarts at lane 0.
        bus.req_valid_i = 4'b0010;
        for (int i = 0; i < 50 && !(m_busy && m_age >= 3 && !m_resp); i++) step();
        chk("rst_wait_reached", 64'(m_busy && m_age >= 3 && !m_resp), 64'd1);
        bus.req_valid_i = '0;
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_outputs();
        @(posedge clk); #2 rst_n = 1'b1;
        grants.delete();
        bus.req_valid_i = '1;
        for (int i = 0; i < 20 && grants.size() < 1; i++) step();
        chk("rst_next_grant", 64'(grants.size() >= 1 ? grants[0] : -1), 64'd0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            drive_rand();
            step();
        end
        drain();

`ifdef MONT_SCHED_TIMEOUT_EN
        // Core never completes: abort after TO WAIT cycles.
        st_never = 1;
        bus.req_valid_i = 4'b1000;
        for (int i = 0; i < 20 && !m_busy; i++) step();
        bus.req_valid_i = '0;
        wait_resp(n_resp + 1, "to_timeout");
        chk("to_err", 64'(last_err), 64'd1);
        chk("to_data", 64'(last_data), 64'd0);
        chk("to_latency", 64'(resp_start_cyc - acc_cyc), 64'(3 + TO));
        st_never = 0;
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
